// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling 8N1 UART receiver feeding a one-entry
// holding register with a valid/ready handshake. Framing errors and
// overruns are reported as single-cycle pulses.
// Optional feature macro: UART_RX_MAJORITY_VOTE_EN -- when defined, every
// sample is the 2-of-3 majority of rxd_s around the bit centre, with the
// decision taken one cycle after the centre count.
module uart_rx_frontend #(
  parameter int CLKS_PER_BIT = 32
) (
  input  logic       CLK_I,
  input  logic       RST_NI,
  input  logic       RXD_I,
  input  logic       READY_I,
  output logic [7:0] DATA_O,
  output logic       VALID_O,
  output logic       FRAME_ERR_O,
  output logic       OVERRUN_O,
  output logic       BUSY_O
);

  localparam int            CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_TGT = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_TGT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic [1:0]    sync_reg;
  logic          rxd_s;
  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    bit_cnt_reg, bit_cnt_next;
  logic [7:0]    shift_reg, shift_next;
  logic [7:0]    data_reg;
  logic          valid_reg;
  logic          frame_err_reg;
  logic          overrun_reg;
  logic          at_target;
  logic          decide;
  logic          sample_bit;
  logic          commit;
  logic          frame_err;

  // Two-flop synchronizer for the asynchronous line, preset to idle (high).
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], RXD_I};
    end
  end

  assign rxd_s = sync_reg[1];

  // Sample point reached: half a bit into the start bit, full bit otherwise.
  always_comb begin
    at_target = 1'b0;
    case (state_reg)
      S_START:        at_target = (cnt_reg == HALF_TGT);
      S_DATA, S_STOP: at_target = (cnt_reg == FULL_TGT);
      default:        at_target = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic rxd_d1_reg;
  logic rxd_d2_reg;
  logic hit_reg;

  // Keep the two previous rxd_s values and remember that the centre count was
  // hit, so the vote over (centre-1, centre, centre+1) resolves one cycle late.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      rxd_d1_reg <= 1'b1;
      rxd_d2_reg <= 1'b1;
      hit_reg    <= 1'b0;
    end else begin
      rxd_d1_reg <= rxd_s;
      rxd_d2_reg <= rxd_d1_reg;
      hit_reg    <= at_target;
    end
  end

  assign decide     = hit_reg;
  assign sample_bit = (rxd_d2_reg & rxd_d1_reg) | (rxd_d2_reg & rxd_s) | (rxd_d1_reg & rxd_s);
`else
  assign decide     = at_target;
  assign sample_bit = rxd_s;
`endif

  // FSM state, counters and shift register.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      state_reg   <= S_IDLE;
      cnt_reg     <= '0;
      bit_cnt_reg <= '0;
      shift_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_cnt_reg <= bit_cnt_next;
      shift_reg   <= shift_next;
    end
  end

  // Next-state logic. The cycle counter free-runs inside a frame and wraps to
  // zero at each sample point; with voting, the decision cycle simply keeps
  // counting from there so the bit grid is unchanged.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg + 1'b1;
    bit_cnt_next = bit_cnt_reg;
    shift_next   = shift_reg;
    commit       = 1'b0;
    frame_err    = 1'b0;
    if (at_target) begin
      cnt_next = '0;
    end
    case (state_reg)
      S_IDLE: begin
        cnt_next     = '0;
        bit_cnt_next = '0;
        if (!rxd_s) begin
          state_next = S_START;
        end
      end
      S_START: begin
        if (decide) begin
          if (sample_bit) begin
            state_next = S_IDLE;
          end else begin
            state_next   = S_DATA;
            bit_cnt_next = '0;
          end
        end
      end
      S_DATA: begin
        if (decide) begin
          shift_next   = {sample_bit, shift_reg[7:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          if (bit_cnt_reg == 3'd7) begin
            state_next = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (decide) begin
          if (sample_bit) begin
            commit     = 1'b1;
            state_next = S_IDLE;
          end else begin
            frame_err  = 1'b1;
            state_next = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        cnt_next = '0;
        if (rxd_s) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Holding register: a consumer read in the commit cycle frees the slot, so
  // only a full register with no read drops the new byte.
  always_ff @(posedge CLK_I or negedge RST_NI) begin
    if (!RST_NI) begin
      data_reg      <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
      overrun_reg   <= 1'b0;
    end else begin
      frame_err_reg <= frame_err;
      overrun_reg   <= 1'b0;
      if (commit) begin
        if (!valid_reg || READY_I) begin
          data_reg  <= shift_reg;
          valid_reg <= 1'b1;
        end else begin
          overrun_reg <= 1'b1;
        end
      end else if (READY_I) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign DATA_O      = data_reg;
  assign VALID_O     = valid_reg;
  assign FRAME_ERR_O = frame_err_reg;
  assign OVERRUN_O   = overrun_reg;
  assign BUSY_O      = (state_reg != S_IDLE);

endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: directed frames on the RX line. A slot-level waveform
// of each frame is built in an array; the expected byte/outcome is derived
// from the line values at each bit centre (2-of-3 around it when the voting
// build is selected) and replayed into a holding-register model that is
// compared with the DUT on every falling clock edge.
module tb_uart_rx_frontend;

  localparam int CPB   = 16;
  localparam int HALF  = CPB / 2;
  localparam int NSLOT = 1024;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif
  localparam int K_BON    = 0;
  localparam int K_COMMIT = 1;
  localparam int K_FERR   = 2;
  localparam int K_GLITCH = 3;
  localparam int K_BOFF   = 4;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic       rxd   = 1'b1;
  logic       ready = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  uart_rx_frontend #(.CLKS_PER_BIT(CPB)) dut (
    .CLK_I      (clk),
    .RST_NI     (rst_n),
    .RXD_I      (rxd),
    .READY_I    (ready),
    .DATA_O     (data),
    .VALID_O    (valid),
    .FRAME_ERR_O(ferr),
    .OVERRUN_O  (ovr),
    .BUSY_O     (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         edge_no;
    int         kind;
    logic [7:0] data;
  } ev_t;

  int         checks   = 0;
  int         errors   = 0;
  int         edge_cnt = 0;
  int         v_cnt    = 0;
  int         f_cnt    = 0;
  int         o_cnt    = 0;
  ev_t        evq[$];
  logic [7:0] m_data   = 8'h00;
  logic       m_valid  = 1'b0;
  logic       m_ferr   = 1'b0;
  logic       m_ovr    = 1'b0;
  logic       m_busy   = 1'b0;
  logic       wave [0:NSLOT-1];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  function automatic void push_ev(input int e, input int k, input logic [7:0] d);
    ev_t ev;
    ev.edge_no = e;
    ev.kind    = k;
    ev.data    = d;
    evq.push_back(ev);
  endfunction

  function automatic void clear_wave();
    for (int k = 0; k < NSLOT; k++) wave[k] = 1'b1;
  endfunction

  // Slot k is the line value during the k-th clock after the falling edge.
  function automatic void build_frame(input logic [7:0] b, input logic stop_bit);
    clear_wave();
    for (int k = 0; k < CPB; k++) begin
      wave[k] = 1'b0;
      for (int i = 0; i < 8; i++) wave[CPB * (i + 1) + k] = b[i];
      wave[CPB * 9 + k] = stop_bit;
    end
  endfunction

  function automatic logic vote(input int c);
    int ones;
    if (MAJ != 0) begin
      ones = 0;
      for (int d = -1; d <= 1; d++) if (wave[c + d] == 1'b1) ones++;
      return (ones >= 2);
    end
    return wave[c];
  endfunction

  // Bit b is centred on slot HALF + CPB*b; the synchronizer adds two edges
  // and voting one more before the outcome is visible.
  function automatic void predict(input int base);
    int         dl;
    logic [7:0] b;
    logic       s;
    dl = 2 + MAJ;
    push_ev(base + 2, K_BON, 8'h00);
    if (vote(HALF)) begin
      push_ev(base + HALF + dl, K_GLITCH, 8'h00);
      $display("frame at edge %0d: expect start glitch, no output", base);
      return;
    end
    for (int i = 0; i < 8; i++) b[i] = vote(HALF + CPB * (i + 1));
    s = vote(HALF + CPB * 9);
    push_ev(base + HALF + CPB * 9 + dl, s ? K_COMMIT : K_FERR, b);
    $display("frame at edge %0d: expect %s byte 0x%02h", base, s ? "commit" : "framing error", b);
  endfunction

  task automatic play(input int nslots, output int base);
    @(negedge clk);
    base = edge_cnt + 1;
    predict(base);
    rxd = wave[0];
    for (int k = 1; k < nslots; k++) begin
      @(negedge clk);
      rxd = wave[k];
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rxd = 1'b1;
    end
  endtask

  task automatic clr_cnt();
    v_cnt = 0;
    f_cnt = 0;
    o_cnt = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    rxd   = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Holding-register model, advanced on every rising edge.
  always @(posedge clk) begin : model
    ev_t        e;
    logic       do_commit;
    logic [7:0] cdata;
    edge_cnt++;
    m_ferr    = 1'b0;
    m_ovr     = 1'b0;
    do_commit = 1'b0;
    cdata     = 8'h00;
    if (!rst_n) begin
      evq.delete();
      m_data  = 8'h00;
      m_valid = 1'b0;
      m_busy  = 1'b0;
    end else begin
      while (evq.size() > 0 && evq[0].edge_no <= edge_cnt) begin
        e = evq.pop_front();
        case (e.kind)
          K_BON:    m_busy = 1'b1;
          K_COMMIT: begin
            do_commit = 1'b1;
            cdata     = e.data;
            m_busy    = 1'b0;
          end
          K_FERR:   m_ferr = 1'b1;
          default:  m_busy = 1'b0;
        endcase
      end
      if (do_commit) begin
        if (!m_valid || ready) begin
          m_data  = cdata;
          m_valid = 1'b1;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("VALID_O", 8'(valid), 8'(m_valid));
    chk("DATA_O", data, m_data);
    chk("FRAME_ERR_O", 8'(ferr), 8'(m_ferr));
    chk("OVERRUN_O", 8'(ovr), 8'(m_ovr));
    chk("BUSY_O", 8'(busy), 8'(m_busy));
    if (valid) v_cnt++;
    if (ferr)  f_cnt++;
    if (ovr)   o_cnt++;
  end

  initial begin : watchdog
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : stim
    int         base;
    logic [7:0] exp_glitch;
    clear_wave();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset DATA_O", data, 8'h00);
    chk("reset VALID_O", 8'(valid), 8'h00);
    chk("reset BUSY_O", 8'(busy), 8'h00);
    #1 rst_n = 1'b1;

    // 0xA5 with the consumer always ready: one-cycle VALID_O.
    ready = 1'b1;
    clr_cnt();
    build_frame(8'hA5, 1'b1);
    play(CPB * 10, base);
    idle(30);
    chk("A5 DATA_O", data, 8'hA5);
    chk("A5 valid cycles", 8'(v_cnt), 8'd1);
    chk("A5 frame errors", 8'(f_cnt), 8'd0);
    chk("A5 overruns", 8'(o_cnt), 8'd0);

    // Short low pulse: start check rejects it.
    clr_cnt();
    clear_wave();
    for (int k = 0; k < 4; k++) wave[k] = 1'b0;
    play(HALF + 5, base);
    chk("glitch BUSY_O cleared", 8'(busy), 8'h00);
    idle(10);
    chk("glitch valid cycles", 8'(v_cnt), 8'd0);

    // 0x3C with a low stop bit, then 40 bit times of break.
    clr_cnt();
    build_frame(8'h3C, 1'b0);
    for (int k = CPB * 10; k < CPB * 50; k++) wave[k] = 1'b0;
    play(CPB * 50, base);
    chk("break BUSY_O held", 8'(busy), 8'h01);
    @(negedge clk);
    push_ev(edge_cnt + 3, K_BOFF, 8'h00);
    rxd = 1'b1;
    idle(20);
    chk("break BUSY_O released", 8'(busy), 8'h00);
    chk("break frame errors", 8'(f_cnt), 8'd1);
    chk("break valid cycles", 8'(v_cnt), 8'd0);

    // 0x11 then 0x22 back to back with no consumer: second byte overruns.
    ready = 1'b0;
    clr_cnt();
    build_frame(8'h11, 1'b1);
    play(CPB * 10, base);
    build_frame(8'h22, 1'b1);
    play(CPB * 10, base);
    idle(30);
    chk("overrun DATA_O held", data, 8'h11);
    chk("overrun VALID_O", 8'(valid), 8'h01);
    chk("overrun pulses", 8'(o_cnt), 8'd1);
    @(negedge clk);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("accept VALID_O dropped", 8'(valid), 8'h00);
    chk("accept DATA_O kept", data, 8'h11);

    // Reset in the middle of data bit 4 of 0xFF, then a clean 0x5A.
    ready = 1'b1;
    build_frame(8'hFF, 1'b1);
    play(CPB * 5 + HALF, base);
    apply_reset();
    repeat (2) @(negedge clk);
    chk("mid-frame reset DATA_O", data, 8'h00);
    chk("mid-frame reset VALID_O", 8'(valid), 8'h00);
    chk("mid-frame reset BUSY_O", 8'(busy), 8'h00);
    clr_cnt();
    build_frame(8'h5A, 1'b1);
    play(CPB * 10, base);
    idle(30);
    chk("5A DATA_O", data, 8'h5A);
    chk("5A valid cycles", 8'(v_cnt), 8'd1);

    // 0x00 with a one-cycle high spike at each data bit centre.
    clr_cnt();
    build_frame(8'h00, 1'b1);
    for (int i = 0; i < 8; i++) wave[HALF + CPB * (i + 1)] = 1'b1;
    play(CPB * 10, base);
    idle(30);
    exp_glitch = (MAJ != 0) ? 8'h00 : 8'hFF;
    chk("centre spike DATA_O", data, exp_glitch);
    chk("centre spike valid cycles", 8'(v_cnt), 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
